tick_countdown_timer: RTL and testbench
=======================================

// Module: tick_countdown_timer
// PURPOSE
//  Seconds countdown timer driven by the 1 kHz (1 ms) single-cycle tick from the clock divider.
//  - Loads a seconds value, counts down on ticks, and supports start, pause, resume and clear.
//  - Exposes the remaining time as seconds + sub-second ms fields for the LCD / segment display path.
//  - Raises a one-cycle done pulse and a level expired flag at zero.
// PARAMETERS
//  SEC_W          8     width of the seconds field (max load 2^SEC_W-1 s)
//  TICKS_PER_SEC  1000  ticks per second; sub-second field counts TICKS_PER_SEC-1..0
//  MS_W           10    width of the sub-second field; must hold TICKS_PER_SEC-1
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous, active-high reset
//  i_tick      in   1      1 ms tick, high exactly one clk cycle per period
//  i_load      in   1      load request (1-cycle strobe)
//  i_load_sec  in   SEC_W  seconds value captured on i_load
//  i_start     in   1      start / resume strobe
//  i_pause     in   1      pause strobe
//  i_clear     in   1      clear strobe
//  o_sec       out  SEC_W  remaining whole seconds
//  o_ms        out  MS_W   remaining sub-second ticks
//  o_state     out  2      0=IDLE 1=RUN 2=PAUSE 3=DONE
//  o_busy      out  1      1 while in RUN or PAUSE
//  o_expired   out  1      1 while in DONE
//  o_done      out  1      one-cycle pulse on the RUN->DONE transition
// BEHAVIOUR
//  Reset (async, any time including mid-count): state=IDLE, o_sec=0, o_ms=0, o_done=0.
//  All outputs are registered. o_busy and o_expired are decoded from the state register.
//  Per-cycle priority: i_clear > i_load > i_pause > i_start > i_tick.
//  i_clear, from any state: go to IDLE, o_sec=0, o_ms=0, no o_done.
//  IDLE:
//   - i_load: o_sec<=i_load_sec, o_ms<=0, stay IDLE.
//   - i_start: go to RUN only if {o_sec,o_ms}!=0; otherwise ignored.
//  RUN, when i_tick is seen, one decrement per tick:
//   - o_ms!=0: o_ms-1.
//   - o_ms==0 and o_sec!=0: o_ms<=TICKS_PER_SEC-1 and o_sec-1 (borrow).
//   - Result reaches {0,0}: go to DONE; o_done high the next cycle for exactly 1 cycle.
//  RUN, other inputs:
//   - i_pause: go to PAUSE; a tick in the same cycle is dropped.
//   - i_load, i_start: ignored.
//  PAUSE:
//   - Ticks ignored; value held.
//   - i_start: go to RUN; the first decrement happens on the next tick after the start cycle.
//   - i_load: reload value, stay PAUSE.
//   - i_pause: no effect.
//  DONE:
//   - Value held at 0; o_expired=1.
//   - i_load: capture value and go to IDLE.
//   - i_start: ignored.
//  Latency: start strobe to RUN state is 1 cycle. Tick to updated o_sec/o_ms is 1 cycle.
//  No wrap below zero: a decrement from {0,0} never occurs.
//  Loading 0 then starting leaves the block in IDLE with no o_done.
//  Simultaneous i_start and i_pause in PAUSE: pause wins, stay PAUSE.
//  Simultaneous i_start and i_pause in IDLE: stay IDLE.
// TESTING (TICKS_PER_SEC=4, tick every 10 clk)
//  1. rst mid-RUN with o_sec=2 -> state=0, o_sec=0, o_ms=0, o_done=0 immediately (async).
//  2. load 2, start, 8 ticks:
//     - o_sec/o_ms go 2/0, 1/3, 1/2, 1/1, 1/0, 0/3, 0/2, 0/1, 0/0.
//     - o_done pulses 1 cycle after the 8th tick; o_expired stays 1.
//  3. load 1, start, 2 ticks, pause, 5 ticks, start, 2 ticks:
//     - Holds 0/2 while paused.
//     - After resume, ends 0/0 in DONE after exactly 4 counted ticks.
//  4. load 0 then start -> stays IDLE, o_done never asserts.
//     start with a tick in the same cycle -> no decrement that cycle.
//  5. i_clear and i_load asserted together in RUN -> IDLE, o_sec=0, o_ms=0.
//     i_load in DONE with 3 -> IDLE, o_sec=3, o_ms=0.
//  6. i_pause asserted on the same cycle as a tick in RUN at 1/0 -> PAUSE holding 1/0.

Source files
------------

// File: rtl/tick_countdown_timer.sv
// Seconds countdown timer advanced by a single-cycle 1 ms tick.
// Holds the remaining time as whole seconds plus sub-second ticks, and supports
// load, start, pause, resume and clear. Reaching zero gives a one-cycle done
// pulse and a level expired flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped, value can be loaded, start needs a non-zero value
//   ST_RUN   | counting down one step per tick
//   ST_PAUSE | value frozen, ticks ignored, start resumes
//   ST_DONE  | reached zero, expired flag high until load or clear
module tick_countdown_timer #(
   parameter int SEC_W         = 8,
   parameter int TICKS_PER_SEC = 1000,
   parameter int MS_W          = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [SEC_W-1:0] i_load_sec,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_clear,
   output logic [SEC_W-1:0] o_sec,
   output logic [MS_W-1:0]  o_ms,
   output logic [1:0]       o_state,
   output logic             o_busy,
   output logic             o_expired,
   output logic             o_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [MS_W-1:0] MS_MAX = MS_W'(TICKS_PER_SEC - 1);

   state_e           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic             done_q, done_d;
   logic             nonzero;

   assign nonzero = (sec_q != '0) || (ms_q != '0);

   // State and value registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sec_q   <= '0;
         ms_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         ms_q    <= ms_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-value logic; strobe priority is clear, load, pause, start, tick.
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      ms_d    = ms_q;
      done_d  = 1'b0;
      if (i_clear) begin
         state_d = ST_IDLE;
         sec_d   = '0;
         ms_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_load) begin
                  sec_d = i_load_sec;
                  ms_d  = '0;
               end else if (i_pause) begin
                  state_d = ST_IDLE;
               end else if (i_start && nonzero) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // load and start are ignored here, so they do not mask a pause or a tick
               if (i_pause) begin
                  state_d = ST_PAUSE;
               end else if (i_tick) begin
                  if (ms_q != '0) begin
                     ms_d = ms_q - 1'b1;
                  end else if (sec_q != '0) begin
                     ms_d  = MS_MAX;
                     sec_d = sec_q - 1'b1;
                  end
                  if ((sec_d == '0) && (ms_d == '0)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (i_load) begin
                  sec_d = i_load_sec;
                  ms_d  = '0;
               end else if (i_pause) begin
                  state_d = ST_PAUSE;
               end else if (i_start && nonzero) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (i_load) begin
                  state_d = ST_IDLE;
                  sec_d   = i_load_sec;
                  ms_d    = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign o_sec     = sec_q;
   assign o_ms      = ms_q;
   assign o_state   = state_q;
   assign o_done    = done_q;
   assign o_busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign o_expired = (state_q == ST_DONE);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer with 4 ticks per second and a tick every 10 clk.
module tb_tick_countdown_timer;

   logic       clk;
   logic       rst;
   logic       i_tick;
   logic       i_load;
   logic [7:0] i_load_sec;
   logic       i_start;
   logic       i_pause;
   logic       i_clear;
   logic [7:0] o_sec;
   logic [2:0] o_ms;
   logic [1:0] o_state;
   logic       o_busy;
   logic       o_expired;
   logic       o_done;

   int total;
   int bad;

   tick_countdown_timer #(
      .SEC_W(8),
      .TICKS_PER_SEC(4),
      .MS_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_tick(i_tick),
      .i_load(i_load),
      .i_load_sec(i_load_sec),
      .i_start(i_start),
      .i_pause(i_pause),
      .i_clear(i_clear),
      .o_sec(o_sec),
      .o_ms(o_ms),
      .o_state(o_state),
      .o_busy(o_busy),
      .o_expired(o_expired),
      .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      repeat (9) step();
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
   endtask

   task automatic load(input logic [7:0] v);
      i_load = 1'b1;
      i_load_sec = v;
      step();
      i_load = 1'b0;
   endtask

   task automatic start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({o_state, o_sec, o_ms, o_done, o_busy, o_expired} !== 16'd0) begin
         bad++;
         $display("FAIL reset_init got st=%0d sec=%0d ms=%0d done=%0b busy=%0b exp=%0b want all 0",
                  o_state, o_sec, o_ms, o_done, o_busy, o_expired);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_run();
      load(8'd3);
      start();
      repeat (3) tick();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd2, 3'd1}) begin
         bad++;
         $display("FAIL pre_reset got st=%0d sec=%0d ms=%0d want st=1 sec=2 ms=1", o_state, o_sec, o_ms);
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({o_state, o_sec, o_ms, o_done} !== 14'd0) begin
         bad++;
         $display("FAIL async_reset got st=%0d sec=%0d ms=%0d done=%0b want 0/0/0/0",
                  o_state, o_sec, o_ms, o_done);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_countdown();
      logic [7:0] es [8];
      logic [2:0] em [8];
      es = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      em = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
      load(8'd2);
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd0, 8'd2, 3'd0}) begin
         bad++;
         $display("FAIL cd_load got st=%0d sec=%0d ms=%0d want st=0 sec=2 ms=0", o_state, o_sec, o_ms);
      end
      start();
      total++;
      if ({o_state, o_busy} !== {2'd1, 1'b1}) begin
         bad++;
         $display("FAIL cd_start got st=%0d busy=%0b want st=1 busy=1", o_state, o_busy);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         total++;
         if ({o_sec, o_ms} !== {es[k], em[k]}) begin
            bad++;
            $display("FAIL cd_seq[%0d] got sec=%0d ms=%0d want sec=%0d ms=%0d", k, o_sec, o_ms, es[k], em[k]);
         end
         total++;
         if (k < 7 && {o_state, o_done} !== {2'd1, 1'b0}) begin
            bad++;
            $display("FAIL cd_run[%0d] got st=%0d done=%0b want st=1 done=0", k, o_state, o_done);
         end else if (k == 7 && {o_state, o_done, o_expired} !== {2'd3, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL cd_done got st=%0d done=%0b exp=%0b want st=3 done=1 exp=1", o_state, o_done, o_expired);
         end
      end
      step();
      total++;
      if ({o_state, o_done, o_expired, o_sec, o_ms} !== {2'd3, 1'b0, 1'b1, 8'd0, 3'd0}) begin
         bad++;
         $display("FAIL cd_after got st=%0d done=%0b exp=%0b sec=%0d ms=%0d want 3/0/1/0/0",
                  o_state, o_done, o_expired, o_sec, o_ms);
      end
   endtask

   task automatic test_pause_resume();
      load(8'd1);
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd0, 8'd1, 3'd0}) begin
         bad++;
         $display("FAIL pr_load got st=%0d sec=%0d ms=%0d want 0/1/0", o_state, o_sec, o_ms);
      end
      start();
      tick();
      tick();
      total++;
      if ({o_sec, o_ms} !== {8'd0, 3'd2}) begin
         bad++;
         $display("FAIL pr_two_ticks got sec=%0d ms=%0d want 0/2", o_sec, o_ms);
      end
      i_pause = 1'b1;
      step();
      i_pause = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if ({o_state, o_sec, o_ms, o_busy} !== {2'd2, 8'd0, 3'd2, 1'b1}) begin
            bad++;
            $display("FAIL pr_hold[%0d] got st=%0d sec=%0d ms=%0d busy=%0b want 2/0/2/1",
                     k, o_state, o_sec, o_ms, o_busy);
         end
      end
      start();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd0, 3'd2}) begin
         bad++;
         $display("FAIL pr_resume got st=%0d sec=%0d ms=%0d want 1/0/2", o_state, o_sec, o_ms);
      end
      tick();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd0, 3'd1}) begin
         bad++;
         $display("FAIL pr_tick3 got st=%0d sec=%0d ms=%0d want 1/0/1", o_state, o_sec, o_ms);
      end
      tick();
      total++;
      if ({o_state, o_sec, o_ms, o_done} !== {2'd3, 8'd0, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL pr_done got st=%0d sec=%0d ms=%0d done=%0b want 3/0/0/1", o_state, o_sec, o_ms, o_done);
      end
   endtask

   task automatic test_zero_and_start_tick();
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      total++;
      if ({o_state, o_sec, o_ms, o_expired} !== 14'd0) begin
         bad++;
         $display("FAIL zs_clear got st=%0d sec=%0d ms=%0d exp=%0b want all 0", o_state, o_sec, o_ms, o_expired);
      end
      load(8'd0);
      start();
      for (int k = 0; k < 20; k++) begin
         if (k == 10) i_tick = 1'b1;
         step();
         i_tick = 1'b0;
         total++;
         if ({o_state, o_done} !== {2'd0, 1'b0}) begin
            bad++;
            $display("FAIL zs_idle[%0d] got st=%0d done=%0b want st=0 done=0", k, o_state, o_done);
         end
      end
      load(8'd2);
      i_start = 1'b1;
      i_pause = 1'b1;
      step();
      i_start = 1'b0;
      i_pause = 1'b0;
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd0, 8'd2, 3'd0}) begin
         bad++;
         $display("FAIL zs_idle_sp got st=%0d sec=%0d ms=%0d want 0/2/0", o_state, o_sec, o_ms);
      end
      load(8'd1);
      i_start = 1'b1;
      i_tick = 1'b1;
      step();
      i_start = 1'b0;
      i_tick = 1'b0;
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd1, 3'd0}) begin
         bad++;
         $display("FAIL zs_start_tick got st=%0d sec=%0d ms=%0d want 1/1/0", o_state, o_sec, o_ms);
      end
   endtask

   task automatic test_clear_and_done_load();
      tick();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd0, 3'd3}) begin
         bad++;
         $display("FAIL cl_tick got st=%0d sec=%0d ms=%0d want 1/0/3", o_state, o_sec, o_ms);
      end
      i_clear = 1'b1;
      i_load = 1'b1;
      i_load_sec = 8'd5;
      step();
      i_clear = 1'b0;
      i_load = 1'b0;
      total++;
      if ({o_state, o_sec, o_ms, o_busy, o_done} !== 15'd0) begin
         bad++;
         $display("FAIL cl_clear_load got st=%0d sec=%0d ms=%0d busy=%0b done=%0b want all 0",
                  o_state, o_sec, o_ms, o_busy, o_done);
      end
      load(8'd1);
      start();
      repeat (4) tick();
      total++;
      if ({o_state, o_done} !== {2'd3, 1'b1}) begin
         bad++;
         $display("FAIL cl_reach_done got st=%0d done=%0b want st=3 done=1", o_state, o_done);
      end
      step();
      start();
      total++;
      if ({o_state, o_expired} !== {2'd3, 1'b1}) begin
         bad++;
         $display("FAIL cl_done_start got st=%0d exp=%0b want st=3 exp=1", o_state, o_expired);
      end
      load(8'd3);
      total++;
      if ({o_state, o_sec, o_ms, o_expired} !== {2'd0, 8'd3, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL cl_done_load got st=%0d sec=%0d ms=%0d exp=%0b want 0/3/0/0",
                  o_state, o_sec, o_ms, o_expired);
      end
   endtask

   task automatic test_pause_on_tick();
      start();
      repeat (8) tick();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd1, 3'd0}) begin
         bad++;
         $display("FAIL pt_reach got st=%0d sec=%0d ms=%0d want 1/1/0", o_state, o_sec, o_ms);
      end
      repeat (9) step();
      i_pause = 1'b1;
      i_tick = 1'b1;
      step();
      i_pause = 1'b0;
      i_tick = 1'b0;
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd2, 8'd1, 3'd0}) begin
         bad++;
         $display("FAIL pt_pause_tick got st=%0d sec=%0d ms=%0d want 2/1/0", o_state, o_sec, o_ms);
      end
      i_start = 1'b1;
      i_pause = 1'b1;
      step();
      i_start = 1'b0;
      i_pause = 1'b0;
      total++;
      if (o_state !== 2'd2) begin
         bad++;
         $display("FAIL pt_pause_wins got st=%0d want st=2", o_state);
      end
      start();
      tick();
      total++;
      if ({o_state, o_sec, o_ms} !== {2'd1, 8'd0, 3'd3}) begin
         bad++;
         $display("FAIL pt_resume_tick got st=%0d sec=%0d ms=%0d want 1/0/3", o_state, o_sec, o_ms);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      i_tick = 1'b0;
      i_load = 1'b0;
      i_load_sec = 8'd0;
      i_start = 1'b0;
      i_pause = 1'b0;
      i_clear = 1'b0;
      test_reset();
      test_reset_mid_run();
      test_countdown();
      test_pause_resume();
      test_zero_and_start_tick();
      test_clear_and_done_load();
      test_pause_on_tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
